// File: rtl/astar_pkg.sv
// Shared A* datapath types: node record, expansion direction and f bubble value.
package astar_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned COORD_W = 16;

    // Bubble / saturation value for f. Named apart from the MAX_F module parameter.
    localparam logic [DATA_W-1:0] ASTAR_MAX_F = 32'hFFFF_FFFF;

    // Node record exchanged with open_list_queue.
    typedef struct packed {
        logic [DATA_W-1:0]  f;
        logic [COORD_W-1:0] node_i;
        logic [COORD_W-1:0] node_j;
    } node_t;

    // Neighbour visiting order: N (j-1), E (i+1), S (j+1), W (i-1).
    typedef enum logic [1:0] {
        DirN = 2'd0,
        DirE = 2'd1,
        DirS = 2'd2,
        DirW = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StIssue,
        StLookup,
        StEmit,
        StFinish
    } state_t;

    // Unsigned add that clamps to the bubble value instead of wrapping.
    function automatic logic [DATA_W-1:0] sat_add(input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
        logic [DATA_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DATA_W] ? ASTAR_MAX_F : s[DATA_W-1:0];
    endfunction

endpackage

// File: rtl/astar_manhattan_h.sv
// Combinational Manhattan distance |i-gi| + |j-gj|, zero-extended and saturated.
module astar_manhattan_h #(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MAP_WIDTH  = 16,
    parameter int unsigned           MAP_HEIGHT = 16,
    parameter logic [DATA_WIDTH-1:0] MAX_F      = {DATA_WIDTH{1'b1}}
) (
    input  logic [MAP_WIDTH-1:0]  node_i_i,
    input  logic [MAP_HEIGHT-1:0] node_j_i,
    input  logic [MAP_WIDTH-1:0]  goal_i_i,
    input  logic [MAP_HEIGHT-1:0] goal_j_i,
    output logic [DATA_WIDTH-1:0] h_o
);

    localparam int unsigned SumW = DATA_WIDTH + 1;

    logic [MAP_WIDTH-1:0]  di;
    logic [MAP_HEIGHT-1:0] dj;
    logic [SumW-1:0]       sum;

    // Absolute per-axis differences followed by a saturating sum.
    always_comb begin
        di  = (node_i_i >= goal_i_i) ? node_i_i - goal_i_i : goal_i_i - node_i_i;
        dj  = (node_j_i >= goal_j_i) ? node_j_i - goal_j_i : goal_j_i - node_j_i;
        sum = SumW'(di) + SumW'(dj);
        h_o = (sum > SumW'(MAX_F)) ? MAX_F : sum[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/astar_neighbor_expander.sv
// Expands one popped A* node: goal check, then N/E/S/W neighbours filtered by
// bounds and obstacle map, each survivor written back with f = g + 1 + h.
module astar_neighbor_expander
    import astar_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           MAP_WIDTH  = 16,
    parameter int unsigned           MAP_HEIGHT = 16,
    parameter int unsigned           GRID_W     = 16,
    parameter int unsigned           GRID_H     = 16,
    parameter logic [DATA_WIDTH-1:0] MAX_F      = {DATA_WIDTH{1'b1}}
) (
    input  logic                  CLK,
    input  logic                  RSTn,
    input  logic [MAP_WIDTH-1:0]  i_goal_i,
    input  logic [MAP_HEIGHT-1:0] i_goal_j,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_node_f,
    input  logic [MAP_WIDTH-1:0]  i_node_i,
    input  logic [MAP_HEIGHT-1:0] i_node_j,
    output logic                  o_ready,
    output logic                  o_map_rd,
    output logic [MAP_WIDTH-1:0]  o_map_i,
    output logic [MAP_HEIGHT-1:0] o_map_j,
    input  logic                  i_map_blocked,
    output logic                  o_wrt,
    output logic [DATA_WIDTH-1:0] o_node_f,
    output logic [MAP_WIDTH-1:0]  o_node_i,
    output logic [MAP_HEIGHT-1:0] o_node_j,
    input  logic                  i_full,
    output logic                  o_goal_found,
    output logic                  o_done
);

    localparam logic [MAP_WIDTH-1:0]  LastI = MAP_WIDTH'(GRID_W - 1);
    localparam logic [MAP_HEIGHT-1:0] LastJ = MAP_HEIGHT'(GRID_H - 1);
    localparam int unsigned           SumW  = DATA_WIDTH + 2;

    state_t                state_q;
    dir_t                  dir_q;
    logic [DATA_WIDTH-1:0] par_f_q;
    logic [MAP_WIDTH-1:0]  par_i_q;
    logic [MAP_HEIGHT-1:0] par_j_q;
    logic [DATA_WIDTH-1:0] g_par_q;
    logic [DATA_WIDTH-1:0] node_f_q;
    logic [MAP_WIDTH-1:0]  node_i_q;
    logic [MAP_HEIGHT-1:0] node_j_q;
    logic                  goal_found_q;
    logic                  done_q;

    logic [DATA_WIDTH-1:0] h_par;
    logic [DATA_WIDTH-1:0] h_nb;
    logic [MAP_WIDTH-1:0]  nb_i;
    logic [MAP_HEIGHT-1:0] nb_j;
    logic                  oob;
    logic                  is_goal;
    logic [DATA_WIDTH-1:0] g_par_c;
    logic [SumW-1:0]       f_sum;
    logic [DATA_WIDTH-1:0] f_child;
    state_t                adv_state;
    dir_t                  adv_dir;
    logic                  last_dir;

    astar_manhattan_h #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAP_WIDTH  (MAP_WIDTH),
        .MAP_HEIGHT (MAP_HEIGHT),
        .MAX_F      (MAX_F)
    ) u_h_par (
        .node_i_i (par_i_q),
        .node_j_i (par_j_q),
        .goal_i_i (i_goal_i),
        .goal_j_i (i_goal_j),
        .h_o      (h_par)
    );

    astar_manhattan_h #(
        .DATA_WIDTH (DATA_WIDTH),
        .MAP_WIDTH  (MAP_WIDTH),
        .MAP_HEIGHT (MAP_HEIGHT),
        .MAX_F      (MAX_F)
    ) u_h_nb (
        .node_i_i (nb_i),
        .node_j_i (nb_j),
        .goal_i_i (i_goal_i),
        .goal_j_i (i_goal_j),
        .h_o      (h_nb)
    );

    // Current neighbour coordinates and whether it falls off the grid.
    always_comb begin
        nb_i = par_i_q;
        nb_j = par_j_q;
        oob  = 1'b0;
        unique case (dir_q)
            DirN: begin
                oob  = (par_j_q == '0);
                nb_j = par_j_q - 1'b1;
            end
            DirE: begin
                oob  = (par_i_q == LastI);
                nb_i = par_i_q + 1'b1;
            end
            DirS: begin
                oob  = (par_j_q == LastJ);
                nb_j = par_j_q + 1'b1;
            end
            DirW: begin
                oob  = (par_i_q == '0);
                nb_i = par_i_q - 1'b1;
            end
        endcase
    end

    // Cost arithmetic and the "move to next direction" decision.
    always_comb begin
        is_goal   = (par_i_q == i_goal_i) && (par_j_q == i_goal_j);
        g_par_c   = (par_f_q >= h_par) ? par_f_q - h_par : '0;
        f_sum     = SumW'(g_par_q) + SumW'(h_nb) + SumW'(1);
        f_child   = (f_sum > SumW'(MAX_F)) ? MAX_F : f_sum[DATA_WIDTH-1:0];
        last_dir  = (dir_q == DirW);
        adv_state = last_dir ? StFinish : StIssue;
        adv_dir   = last_dir ? dir_q : dir_t'(dir_q + 2'd1);
    end

    // Expansion FSM with registered node outputs and status pulses.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q      <= StIdle;
            dir_q        <= DirN;
            par_f_q      <= '0;
            par_i_q      <= '0;
            par_j_q      <= '0;
            g_par_q      <= '0;
            node_f_q     <= '0;
            node_i_q     <= '0;
            node_j_q     <= '0;
            goal_found_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            goal_found_q <= 1'b0;
            done_q       <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (i_valid) begin
                        par_f_q <= i_node_f;
                        par_i_q <= i_node_i;
                        par_j_q <= i_node_j;
                        state_q <= StCheck;
                    end
                end
                StCheck: begin
                    if (par_f_q == MAX_F) begin
                        state_q <= StIdle;
                    end else if (is_goal) begin
                        goal_found_q <= 1'b1;
                        state_q      <= StIdle;
                    end else begin
                        g_par_q <= g_par_c;
                        dir_q   <= DirN;
                        state_q <= StIssue;
                    end
                end
                StIssue: begin
                    if (oob) begin
                        state_q <= adv_state;
                        dir_q   <= adv_dir;
                        done_q  <= last_dir;
                    end else begin
                        state_q <= StLookup;
                    end
                end
                StLookup: begin
                    if (i_map_blocked) begin
                        state_q <= adv_state;
                        dir_q   <= adv_dir;
                        done_q  <= last_dir;
                    end else begin
                        node_f_q <= f_child;
                        node_i_q <= nb_i;
                        node_j_q <= nb_j;
                        state_q  <= StEmit;
                    end
                end
                StEmit: begin
                    if (!i_full) begin
                        state_q <= adv_state;
                        dir_q   <= adv_dir;
                        done_q  <= last_dir;
                    end
                end
                StFinish: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // Map strobe and write strobe decode directly from state.
    always_comb begin
        o_ready      = (state_q == StIdle);
        o_map_rd     = (state_q == StIssue) && !oob;
        o_map_i      = o_map_rd ? nb_i : '0;
        o_map_j      = o_map_rd ? nb_j : '0;
        o_wrt        = (state_q == StEmit) && !i_full;
        o_node_f     = node_f_q;
        o_node_i     = node_i_q;
        o_node_j     = node_j_q;
        o_goal_found = goal_found_q;
        o_done       = done_q;
    end

endmodule

// File: tb/tb_astar_neighbor_expander.sv
// Directed bench for astar_neighbor_expander with a behavioural expansion model.
module tb_astar_neighbor_expander;

    localparam longint MAXF = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        longint f;
        int     i;
        int     j;
    } ent_t;

    logic        CLK;
    logic        RSTn;
    logic [15:0] i_goal_i;
    logic [15:0] i_goal_j;
    logic        i_valid;
    logic [31:0] i_node_f;
    logic [15:0] i_node_i;
    logic [15:0] i_node_j;
    logic        o_ready;
    logic        o_map_rd;
    logic [15:0] o_map_i;
    logic [15:0] o_map_j;
    logic        i_map_blocked;
    logic        o_wrt;
    logic [31:0] o_node_f;
    logic [15:0] o_node_i;
    logic [15:0] o_node_j;
    logic        i_full;
    logic        o_goal_found;
    logic        o_done;

    int checks = 0;
    int errors = 0;

    ent_t exp_wr[$];
    ent_t exp_rd[$];
    ent_t act_wr[$];
    int   exp_goal = 0;
    int   exp_done = 0;
    int   goal_cnt = 0;
    int   done_cnt = 0;
    int   rd_cnt   = 0;
    int   wr_cnt   = 0;

    bit   blocked[0:15][0:15];
    int   req_seq = 0;
    int   served_seq = 0;
    int   req_i = 0;
    int   req_j = 0;

    astar_neighbor_expander dut (
        .CLK           (CLK),
        .RSTn          (RSTn),
        .i_goal_i      (i_goal_i),
        .i_goal_j      (i_goal_j),
        .i_valid       (i_valid),
        .i_node_f      (i_node_f),
        .i_node_i      (i_node_i),
        .i_node_j      (i_node_j),
        .o_ready       (o_ready),
        .o_map_rd      (o_map_rd),
        .o_map_i       (o_map_i),
        .o_map_j       (o_map_j),
        .i_map_blocked (i_map_blocked),
        .o_wrt         (o_wrt),
        .o_node_f      (o_node_f),
        .o_node_i      (o_node_i),
        .o_node_j      (o_node_j),
        .i_full        (i_full),
        .o_goal_found  (o_goal_found),
        .o_done        (o_done)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic longint mh(input int ai, input int aj);
        int gi;
        int gj;
        gi = int'(i_goal_i);
        gj = int'(i_goal_j);
        return longint'((ai > gi ? ai - gi : gi - ai) + (aj > gj ? aj - gj : gj - aj));
    endfunction

    // Expected map reads and writes for one popped node, straight from the rules.
    task automatic model_expand(input longint f, input int ni, input int nj);
        longint g;
        longint fc;
        int     ci;
        int     cj;
        if (f == MAXF) return;
        if (ni == int'(i_goal_i) && nj == int'(i_goal_j)) begin
            exp_goal++;
            return;
        end
        g = (f >= mh(ni, nj)) ? f - mh(ni, nj) : 0;
        for (int d = 0; d < 4; d++) begin
            ci = ni + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
            cj = nj + ((d == 2) ? 1 : 0) - ((d == 0) ? 1 : 0);
            if (ci < 0 || ci > 15 || cj < 0 || cj > 15) continue;
            exp_rd.push_back('{0, ci, cj});
            if (blocked[ci][cj]) continue;
            fc = g + 1 + mh(ci, cj);
            if (fc > MAXF) fc = MAXF;
            exp_wr.push_back('{fc, ci, cj});
        end
        exp_done++;
    endtask

    // Per-cycle comparison of map reads and writes against the model queues.
    always @(negedge CLK) begin
        ent_t e;
        if (RSTn) begin
            chk("wrt_while_full", longint'(o_wrt && i_full), 0);
            if (o_map_rd) begin
                rd_cnt++;
                req_seq++;
                req_i = int'(o_map_i);
                req_j = int'(o_map_j);
                chk("map_rd_expected", longint'(exp_rd.size() != 0), 1);
                if (exp_rd.size() != 0) begin
                    e = exp_rd.pop_front();
                    chk("map_rd_i", longint'(o_map_i), longint'(e.i));
                    chk("map_rd_j", longint'(o_map_j), longint'(e.j));
                end
            end
            if (o_wrt) begin
                wr_cnt++;
                act_wr.push_back('{longint'(o_node_f), int'(o_node_i), int'(o_node_j)});
                chk("wrt_expected", longint'(exp_wr.size() != 0), 1);
                if (exp_wr.size() != 0) begin
                    e = exp_wr.pop_front();
                    chk("wrt_f", longint'(o_node_f), e.f);
                    chk("wrt_i", longint'(o_node_i), longint'(e.i));
                    chk("wrt_j", longint'(o_node_j), longint'(e.j));
                end
            end
            if (o_goal_found) goal_cnt++;
            if (o_done) done_cnt++;
        end
    end

    // Obstacle map: answer valid for the cycle after each read strobe.
    always @(posedge CLK) begin
        #1;
        if (req_seq != served_seq) begin
            served_seq    = req_seq;
            i_map_blocked = blocked[req_i][req_j];
        end else begin
            i_map_blocked = 1'b0;
        end
    end

    // Present a node and return just after the accepting edge.
    task automatic send(input logic [31:0] f, input int ni, input int nj);
        int t;
        t = 0;
        @(negedge CLK);
        while (!o_ready && t < 100) begin
            @(negedge CLK);
            t++;
        end
        chk("ready_timeout", longint'(t < 100), 1);
        i_valid  = 1'b1;
        i_node_f = f;
        i_node_i = ni[15:0];
        i_node_j = nj[15:0];
        @(posedge CLK);
        #1 i_valid = 1'b0;
    endtask

    task automatic finish_node(input string name);
        int t;
        t = 0;
        while ((done_cnt < exp_done || goal_cnt < exp_goal) && t < 200) begin
            @(negedge CLK);
            t++;
        end
        chk({name, "_timeout"}, longint'(t < 200), 1);
        repeat (3) @(negedge CLK);
        chk({name, "_wr_left"}, longint'(exp_wr.size()), 0);
        chk({name, "_rd_left"}, longint'(exp_rd.size()), 0);
        chk({name, "_done_cnt"}, longint'(done_cnt), longint'(exp_done));
        chk({name, "_goal_cnt"}, longint'(goal_cnt), longint'(exp_goal));
        chk({name, "_ready"}, longint'(o_ready), 1);
    endtask

    initial begin
        int rd0;
        int wr0;
        int done0;
        RSTn          = 1'b0;
        i_valid       = 1'b0;
        i_node_f      = '0;
        i_node_i      = '0;
        i_node_j      = '0;
        i_full        = 1'b0;
        i_map_blocked = 1'b0;
        i_goal_i      = 16'd5;
        i_goal_j      = 16'd5;
        repeat (2) @(negedge CLK);
        chk("rst_ready", longint'(o_ready), 1);
        chk("rst_wrt", longint'(o_wrt), 0);
        chk("rst_map_rd", longint'(o_map_rd), 0);
        chk("rst_done", longint'(o_done), 0);
        chk("rst_goal", longint'(o_goal_found), 0);
        chk("rst_node_f", longint'(o_node_f), 0);
        RSTn = 1'b1;

        // Interior node, clear map.
        act_wr.delete();
        model_expand(6, 3, 5);
        send(32'd6, 3, 5);
        finish_node("s1");
        chk("s1_nwr", longint'(act_wr.size()), 4);
        if (act_wr.size() == 4) begin
            chk("s1_w0_f", act_wr[0].f, 8); chk("s1_w0_j", longint'(act_wr[0].j), 4);
            chk("s1_w1_f", act_wr[1].f, 6); chk("s1_w1_i", longint'(act_wr[1].i), 4);
            chk("s1_w2_f", act_wr[2].f, 8); chk("s1_w2_j", longint'(act_wr[2].j), 6);
            chk("s1_w3_f", act_wr[3].f, 8); chk("s1_w3_i", longint'(act_wr[3].i), 2);
        end

        // Corner node: N and W skipped without map reads.
        act_wr.delete();
        rd0 = rd_cnt;
        model_expand(10, 0, 0);
        send(32'd10, 0, 0);
        finish_node("s2");
        chk("s2_nrd", longint'(rd_cnt - rd0), 2);
        chk("s2_nwr", longint'(act_wr.size()), 2);
        if (act_wr.size() == 2) begin
            chk("s2_w0", longint'(act_wr[0].i * 256 + act_wr[0].j), 256);
            chk("s2_w0_f", act_wr[0].f, 10);
            chk("s2_w1", longint'(act_wr[1].i * 256 + act_wr[1].j), 1);
            chk("s2_w1_f", act_wr[1].f, 10);
        end

        // f below h clamps g to zero.
        model_expand(3, 0, 0);
        send(32'd3, 0, 0);
        finish_node("clamp");

        // East neighbour blocked.
        act_wr.delete();
        rd0 = rd_cnt;
        blocked[4][5] = 1'b1;
        model_expand(6, 3, 5);
        send(32'd6, 3, 5);
        finish_node("s3");
        blocked[4][5] = 1'b0;
        chk("s3_nrd", longint'(rd_cnt - rd0), 4);
        chk("s3_nwr", longint'(act_wr.size()), 3);
        if (act_wr.size() == 3) begin
            chk("s3_w1_i", longint'(act_wr[1].i), 3);
            chk("s3_w1_f", act_wr[1].f, 8);
        end

        // Goal popped: pulse two cycles after accept, no reads or writes.
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        model_expand(7, 5, 5);
        send(32'd7, 5, 5);
        @(negedge CLK);
        chk("goal_early", longint'(o_goal_found), 0);
        @(negedge CLK);
        chk("goal_pulse", longint'(o_goal_found), 1);
        @(negedge CLK);
        chk("goal_one_cycle", longint'(o_goal_found), 0);
        finish_node("s4");
        chk("s4_nrd", longint'(rd_cnt - rd0), 0);
        chk("s4_nwr", longint'(wr_cnt - wr0), 0);

        // Back-pressure for five cycles at the first emit.
        act_wr.delete();
        model_expand(6, 3, 5);
        i_full = 1'b1;
        send(32'd6, 3, 5);
        repeat (3) @(posedge CLK);
        #1;
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            chk("hold_wrt", longint'(o_wrt), 0);
            chk("hold_f", longint'(o_node_f), 8);
            chk("hold_ij", longint'(o_node_i) * 256 + longint'(o_node_j), 3 * 256 + 4);
        end
        @(posedge CLK);
        #1 i_full = 1'b0;
        finish_node("s5");
        chk("s5_nwr", longint'(act_wr.size()), 4);

        // Saturation of f near the bubble value.
        act_wr.delete();
        model_expand(64'hFFFF_FFFE, 3, 5);
        send(32'hFFFF_FFFE, 3, 5);
        finish_node("sat");
        if (act_wr.size() == 4) begin
            chk("sat_w0_f", act_wr[0].f, 64'hFFFF_FFFF);
            chk("sat_w1_f", act_wr[1].f, 64'hFFFF_FFFE);
        end

        // Bubble dropped.
        wr0 = wr_cnt;
        send(32'hFFFF_FFFF, 3, 5);
        @(negedge CLK);
        chk("bubble_busy", longint'(o_ready), 0);
        @(negedge CLK);
        chk("bubble_ready", longint'(o_ready), 1);
        finish_node("bubble");
        chk("bubble_nwr", longint'(wr_cnt - wr0), 0);

        // Reset while a write is being offered.
        done0 = exp_done;
        model_expand(6, 3, 5);
        i_full = 1'b1;
        send(32'd6, 3, 5);
        repeat (3) @(posedge CLK);
        #2 i_full = 1'b0;
        #1;
        chk("rst_emit_wrt_before", longint'(o_wrt), 1);
        RSTn = 1'b0;
        #1;
        chk("rst_emit_wrt", longint'(o_wrt), 0);
        chk("rst_emit_ready", longint'(o_ready), 1);
        chk("rst_emit_node_f", longint'(o_node_f), 0);
        exp_wr.delete();
        exp_rd.delete();
        exp_done = done0;
        @(negedge CLK);
        RSTn = 1'b1;
        wr0 = wr_cnt;
        repeat (10) @(negedge CLK);
        chk("rst_emit_nwr", longint'(wr_cnt - wr0), 0);
        chk("rst_emit_done", longint'(done_cnt), longint'(exp_done));
        chk("rst_emit_idle", longint'(o_ready), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/astar_neighbor_expander.md
Name: astar_neighbor_expander

Overview:
- Downstream consumer and upstream producer of open_list_queue in the A* datapath.
- Accepts one node popped from the open list and checks it against the goal.
- Otherwise generates its 4-connected neighbours and filters them for map bounds and obstacles.
- Computes each surviving neighbour's f = g+1+h (Manhattan h) and writes it back into the open list.

Parameters:
DATA_WIDTH, 32, width of f/g/h values
MAP_WIDTH, 16, bit width of i coordinate
MAP_HEIGHT, 16, bit width of j coordinate
GRID_W, 16, number of valid columns (legal i = 0..GRID_W-1)
GRID_H, 16, number of valid rows (legal j = 0..GRID_H-1)
MAX_F, 32'hFFFFFFFF, bubble/saturation value for f

Ports:
CLK  input  1  clock, rising edge
RSTn  input  1  asynchronous active-low reset
i_goal_i  input  MAP_WIDTH  goal column, static during search
i_goal_j  input  MAP_HEIGHT  goal row, static during search
i_valid  input  1  popped node valid (from open list)
i_node_f  input  DATA_WIDTH  popped node f
i_node_i  input  MAP_WIDTH  popped node column
i_node_j  input  MAP_HEIGHT  popped node row
o_ready  output  1  expander can accept a node
o_map_rd  output  1  obstacle map read strobe
o_map_i  output  MAP_WIDTH  map read column
o_map_j  output  MAP_HEIGHT  map read row
i_map_blocked  input  1  obstacle bit, valid exactly 1 cycle after o_map_rd
o_wrt  output  1  write neighbour into open list
o_node_f  output  DATA_WIDTH  neighbour f
o_node_i  output  MAP_WIDTH  neighbour column
o_node_j  output  MAP_HEIGHT  neighbour row
i_full  input  1  open list full (back-pressure)
o_goal_found  output  1  one-cycle pulse: goal node popped
o_done  output  1  one-cycle pulse: expansion of a node finished

Behaviour:
- Clock CLK; reset RSTn is asynchronous, active-low.
- Reset: state=IDLE; o_ready=1; all other outputs 0; neighbour index, held node and registers cleared. Reset mid-expansion drops the node and any pending neighbour; nothing is written.
- Handshake: node accepted on a rising edge with i_valid && o_ready. o_ready=1 only in IDLE.
- FSM states: IDLE, CHECK, ISSUE, LOOKUP, EMIT, FINISH.
- IDLE: on accept, latch node and go to CHECK.
- CHECK:
  - f==MAX_F (bubble): drop, go to IDLE; no pulses, no writes.
  - node==goal: o_goal_found=1 for one cycle, no map reads or writes, go to IDLE.
  - Otherwise: g_par = f - h(node), clamped to 0 if f < h. Direction index d=0. Go to ISSUE.
- Direction order is fixed: d0=N (j-1), d1=E (i+1), d2=S (j+1), d3=W (i-1).
- ISSUE:
  - Neighbour out of bounds (j==0 for N, i==GRID_W-1 for E, j==GRID_H-1 for S, i==0 for W): skip, no map read, d++ (1 cycle).
  - Otherwise: o_map_rd=1 with o_map_i/o_map_j = neighbour, go to LOOKUP.
- LOOKUP: sample i_map_blocked. Blocked -> d++, back to ISSUE. Free -> register o_node_* with f_child = g_par+1+h(neighbour), saturating at MAX_F; go to EMIT.
- EMIT: o_wrt = !i_full (combinational). On a cycle with o_wrt=1: d++, go to ISSUE. While i_full=1, o_node_* are held stable.
- After d3 is processed (any path), go to FINISH: o_done=1 for one cycle, then IDLE.
- Arithmetic: h = |i-gi| + |j-gj|, coordinates zero-extended to DATA_WIDTH. All sums are unsigned and saturate at MAX_F; there is no wrap-around.
- Latency per direction: out-of-bounds 1 cycle; blocked 2 cycles; emitted ≥3 cycles (ISSUE, LOOKUP, EMIT).
- Never more than one outstanding map read. Each neighbour produces exactly one o_wrt.

Decomposition:
- Shared package astar_pkg: node_t struct (f, node_i, node_j) shared with open_list_queue; dir_t enum (N, E, S, W); MAX_F constant; saturating-add function.
- Sub-module astar_manhattan_h: combinational |di|+|dj| to DATA_WIDTH. Instantiated twice: parent h and neighbour h.

Test Plan:
- Goal (5,5), node (3,5) f=6, map clear -> g_par=4; writes in order (3,4) f=8, (4,5) f=6, (3,6) f=8, (2,5) f=8; then one o_done pulse.
- Goal (5,5), corner node (0,0) f=10 -> N and W skipped with no map reads; writes (1,0) f=10 and (0,1) f=10; o_done.
- As scenario 1 with (4,5) blocked -> exactly three writes, (3,4), (3,6), (2,5), each f=8; four map reads.
- Node (5,5) f=7, goal (5,5) -> o_goal_found pulse 2 cycles after accept; zero o_map_rd and zero o_wrt.
- Scenario 1 with i_full high 5 cycles at first EMIT -> o_wrt low for those 5 cycles, (3,4)/f=8 held stable, then all 4 writes complete in order.
- Input f=32'hFFFFFFFF -> dropped, o_ready back to 1 next cycle, no pulses. Separately, RSTn low during EMIT -> o_wrt=0 immediately, state IDLE, o_ready=1.
